// File: rtl/spi_slave_if_if.sv
// Bundles the SPI pins and the RAM-side word/byte handshake of the SPI slave front-end.
// The slave modport is the front-end's view; the master modport is the SPI host/RAM side.
interface spi_slave_if_if #(
    parameter int DATA_W = 8
);
    logic                SS_n;
    logic                MOSI;
    logic                MISO;
    logic [DATA_W+1:0]   rx_data;
    logic                rx_valid;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front-end (mode 0, MSB first, clk is SCK): turns MOSI frames into {cmd, payload}
// words for the RAM and shifts the returned read byte out on MISO.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | waiting for SS_n low
// CHK_CMD   | sampling the first frame bit, which picks the framing below
// WRITE     | shifting a write-address/write-data word, then holding
// READ_ADD  | shifting a read-address word, then holding
// READ_DATA | shifting a read-data word, then awaiting tx_valid and sending the byte
module spi_slave_if #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_slave_if_if.slave bus
);
    localparam int W     = DATA_W + 2;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    logic [2:0]        state_q,        state_d;
    logic [CNT_W-1:0]  bit_cnt_q,      bit_cnt_d;
    logic [W-2:0]      rx_shift_q,     rx_shift_d;
    logic [W-1:0]      rx_data_q,      rx_data_d;
    logic              rx_valid_q,     rx_valid_d;
    logic              rd_addr_seen_q, rd_addr_seen_d;
    logic              word_done_q,    word_done_d;
    logic [DATA_W-1:0] tx_shift_q,     tx_shift_d;
    logic [CNT_W-1:0]  tx_cnt_q,       tx_cnt_d;
    logic              tx_taken_q,     tx_taken_d;
    logic              miso_q,         miso_d;

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        word_done_d    = word_done_q;
        tx_shift_d     = tx_shift_q;
        tx_cnt_d       = tx_cnt_q;
        tx_taken_d     = tx_taken_q;
        miso_d         = 1'b0;

        if (bus.SS_n && (state_q != IDLE)) begin
            // Abort: partial rx word and any partially sent tx byte are dropped.
            state_d     = IDLE;
            bit_cnt_d   = '0;
            rx_shift_d  = '0;
            word_done_d = 1'b0;
            tx_shift_d  = '0;
            tx_cnt_d    = '0;
            tx_taken_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    word_done_d = 1'b0;
                    tx_shift_d  = '0;
                    tx_cnt_d    = '0;
                    tx_taken_d  = 1'b0;
                    if (!bus.SS_n) begin
                        state_d = CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    rx_shift_d = {rx_shift_q[W-3:0], bus.MOSI};
                    bit_cnt_d  = '0;
                    if (!bus.MOSI) begin
                        state_d = WRITE;
                    end else if (rd_addr_seen_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!word_done_q) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d   = {rx_shift_q, bus.MOSI};
                            rx_valid_d  = 1'b1;
                            word_done_d = 1'b1;
                            bit_cnt_d   = '0;
                            if (state_q == READ_ADD) begin
                                rd_addr_seen_d = 1'b1;
                            end else if (state_q == READ_DATA) begin
                                rd_addr_seen_d = 1'b0;
                            end
                        end else begin
                            rx_shift_d = {rx_shift_q[W-3:0], bus.MOSI};
                            bit_cnt_d  = bit_cnt_q + CNT_ONE;
                        end
                    end else if (state_q == READ_DATA) begin
                        // One byte per frame: once taken, later tx_valid pulses are ignored.
                        if (tx_cnt_q != '0) begin
                            miso_d     = tx_shift_q[DATA_W-1];
                            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                            tx_cnt_d   = tx_cnt_q - CNT_ONE;
                        end else if (!tx_taken_q && bus.tx_valid) begin
                            tx_shift_d = bus.tx_data;
                            tx_cnt_d   = LAST_BIT;
                            tx_taken_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            word_done_q    <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            tx_taken_q     <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            word_done_q    <= word_done_d;
            tx_shift_q     <= tx_shift_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_taken_q     <= tx_taken_d;
            miso_q         <= miso_d;
        end
    end
endmodule
